// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_mem_pkg : MEM stage state encoding, memSize and wbSel codes         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RV  = 2'd2,
    DONE     = 2'd3
  } mem_state_t;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_NPC4 = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_align : shift a load word to bit 0 and sign/zero extend by size      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module load_align
  import riscv_mem_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] rdata,
  input  logic [1:0]   offset,
  input  logic [2:0]   size,
  output logic [N-1:0] data
);

  logic [N-1:0] sh;

  always_comb begin
    sh = rdata >> {offset, 3'b000};
    case (size)
      MEM_B:   data = {{(N-8){sh[7]}}, sh[7:0]};
      MEM_H:   data = {{(N-16){sh[15]}}, sh[15:0]};
      MEM_BU:  data = {{(N-8){1'b0}}, sh[7:0]};
      MEM_HU:  data = {{(N-16){1'b0}}, sh[15:0]};
      default: data = sh;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/register_generic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | register_generic : enabled register with synchronous active-high reset    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module register_generic #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memory_stage : pipeline MEM stage, req/gnt/rvalid port and MEM/WB regs    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module memory_stage
  import riscv_mem_pkg::*;
#(
  parameter int N    = 32,
  parameter int REGA = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regEn,
  input  logic [N-1:0]    ALUres,
  input  logic [N-1:0]    Bout,
  input  logic [N-1:0]    NPC4_IN,
  input  logic [N-1:0]    ImmIN,
  input  logic            memRd,
  input  logic            memWr,
  input  logic [2:0]      memSize,
  input  logic [1:0]      wbSel,
  input  logic [REGA-1:0] rdIn,
  input  logic            regWrIn,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [N-1:0]    dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [N-1:0]    dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [N-1:0]    dmem_rdata,
  output logic            stall,
  output logic            misaligned,
  output logic [N-1:0]    wbData,
  output logic [REGA-1:0] rdOut,
  output logic            regWrOut
);

  mem_state_t   state_q, state_d;
  logic [N-1:0] ld_data_q, ld_data_d;
  logic [N-1:0] ld_ext;
  logic [N-1:0] wb_data_d;
  logic         acc, fault, req, complete, wb_en, reg_wr_d;

  load_align #(.N(N)) u_load_align (
    .rdata  (dmem_rdata),
    .offset (ALUres[1:0]),
    .size   (memSize),
    .data   (ld_ext)
  );

  always_comb begin
    acc      = memRd | memWr;
    fault    = acc & ((((memSize == MEM_H) || (memSize == MEM_HU)) & ALUres[0]) |
                      ((memSize == MEM_W) & (|ALUres[1:0])));
    req      = 1'b0;
    complete = 1'b0;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        if (acc && !fault && regEn) begin
          req = 1'b1;
          if (dmem_gnt) begin
            if (memWr) complete = 1'b1;
            else       state_d  = WAIT_RV;
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (dmem_gnt) begin
          if (memWr) complete = 1'b1;
          else       state_d  = WAIT_RV;
        end
      end
      WAIT_RV:  complete = dmem_rvalid;
      DONE:     if (regEn) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // A completion with the pipeline frozen parks the result in DONE.
    if (complete) state_d = regEn ? IDLE : DONE;

    stall      = ~rst & (state_q != DONE) & acc & ~fault & ~complete;
    dmem_req   = ~rst & req;
    misaligned = ~rst & (state_q == IDLE) & fault & regEn;
    wb_en      = regEn & ~stall;
    reg_wr_d   = stall ? 1'b0 : (regWrIn & ~fault);
    ld_data_d  = ((state_q == WAIT_RV) && dmem_rvalid) ? ld_ext : ld_data_q;
  end

  always_comb begin
    dmem_we    = memWr;
    dmem_addr  = {ALUres[N-1:2], 2'b00};
    dmem_be    = 4'b1111;
    dmem_wdata = Bout;
    if (memWr) begin
      case (memSize[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << ALUres[1:0];
          dmem_wdata = {4{Bout[7:0]}};
        end
        2'b01: begin
          dmem_be    = ALUres[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{Bout[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (wbSel)
      WB_ALU:  wb_data_d = ALUres;
      WB_MEM:  wb_data_d = (state_q == DONE) ? ld_data_q : ld_ext;
      WB_NPC4: wb_data_d = NPC4_IN;
      default: wb_data_d = ImmIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_data_q <= ld_data_d;
    end
  end

  register_generic #(.W(N)) u_wb_data (
    .clk (clk), .rst (rst), .en (wb_en), .d (wb_data_d), .q (wbData)
  );

  register_generic #(.W(REGA)) u_rd (
    .clk (clk), .rst (rst), .en (wb_en), .d (rdIn), .q (rdOut)
  );

  // A stall edge clears the write enable so WB sees a bubble.
  register_generic #(.W(1)) u_reg_wr (
    .clk (clk), .rst (rst), .en (wb_en | stall), .d (reg_wr_d), .q (regWrOut)
  );

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_memory_stage : directed self-checking bench for memory_stage           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_memory_stage;

  logic        clk, rst, regEn;
  logic [31:0] ALUres, Bout, NPC4_IN, ImmIN;
  logic        memRd, memWr;
  logic [2:0]  memSize;
  logic [1:0]  wbSel;
  logic [4:0]  rdIn;
  logic        regWrIn;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall, misaligned;
  logic [31:0] wbData;
  logic [4:0]  rdOut;
  logic        regWrOut;

  int checks   = 0;
  int failures = 0;

  memory_stage #(.N(32), .REGA(5)) dut (
    .clk(clk), .rst(rst), .regEn(regEn), .ALUres(ALUres), .Bout(Bout),
    .NPC4_IN(NPC4_IN), .ImmIN(ImmIN), .memRd(memRd), .memWr(memWr),
    .memSize(memSize), .wbSel(wbSel), .rdIn(rdIn), .regWrIn(regWrIn),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall(stall),
    .misaligned(misaligned), .wbData(wbData), .rdOut(rdOut), .regWrOut(regWrOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    memRd = 0; memWr = 0; memSize = 3'b010; wbSel = 2'b00; ALUres = 0; Bout = 0;
    NPC4_IN = 0; ImmIN = 0; rdIn = 0; regWrIn = 0; dmem_gnt = 0; dmem_rvalid = 0;
    dmem_rdata = 0; regEn = 1;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    memRd = 1; ALUres = 32'h40; dmem_gnt = 1;
    step(); step();
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if ({wbData, rdOut, regWrOut, misaligned} !== 39'd0) begin failures++; $display("FAIL reset_regs got=%h/%h/%b/%b exp=0", wbData, rdOut, regWrOut, misaligned); end
    clear_inputs();
    rst = 0;
  endtask

  task automatic test_store();
    memWr = 1; memSize = 3'b010; ALUres = 32'h100; Bout = 32'hDEADBEEF; dmem_gnt = 1;
    rdIn = 5'd3; regWrIn = 0; wbSel = 2'b00;
    #1;
    checks++; if ({dmem_req, dmem_we, dmem_be} !== 6'b11_1111) begin failures++; $display("FAIL sw_req_we_be got=%b%b%b exp=111111", dmem_req, dmem_we, dmem_be); end
    checks++; if (dmem_addr !== 32'h100 || dmem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_addr_data got=%h/%h exp=00000100/deadbeef", dmem_addr, dmem_wdata); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sw_stall got=%b exp=0", stall); end
    step();
    checks++; if (regWrOut !== 1'b0 || rdOut !== 5'd3 || wbData !== 32'h100) begin failures++; $display("FAIL sw_wb got=%b/%h/%h exp=0/03/00000100", regWrOut, rdOut, wbData); end
    // byte store to lane 3, then halfword to upper half
    memSize = 3'b000; ALUres = 32'h103; Bout = 32'h12345678;
    #1;
    checks++; if (dmem_be !== 4'b1000 || dmem_wdata !== 32'h78787878) begin failures++; $display("FAIL sb_lanes got=%b/%h exp=1000/78787878", dmem_be, dmem_wdata); end
    step();
    memSize = 3'b001; ALUres = 32'h102;
    #1;
    checks++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'h56785678 || stall !== 1'b0) begin failures++; $display("FAIL sh_lanes got=%b/%h/%b exp=1100/56785678/0", dmem_be, dmem_wdata, stall); end
    step();
    clear_inputs();
  endtask

  task automatic test_lb();
    memRd = 1; memSize = 3'b000; ALUres = 32'h203; wbSel = 2'b01; rdIn = 5'd5; regWrIn = 1;
    dmem_gnt = 1;
    #1;
    checks++; if ({dmem_req, dmem_we, dmem_be, stall} !== 7'b1_0_1111_1) begin failures++; $display("FAIL lb_issue got=%b%b%b%b exp=1011111", dmem_req, dmem_we, dmem_be, stall); end
    step();
    checks++; if (regWrOut !== 1'b0) begin failures++; $display("FAIL lb_bubble got=%b exp=0", regWrOut); end
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h80FF0000;
    #1;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL lb_rv got=%b/%b exp=0/0", dmem_req, stall); end
    step();
    checks++; if (wbData !== 32'hFFFFFF80 || regWrOut !== 1'b1 || rdOut !== 5'd5) begin failures++; $display("FAIL lb_wb got=%h/%b/%h exp=ffffff80/1/05", wbData, regWrOut, rdOut); end
    clear_inputs();
  endtask

  task automatic test_lhu_delayed_gnt();
    memRd = 1; memSize = 3'b101; ALUres = 32'h202; wbSel = 2'b01; rdIn = 5'd6; regWrIn = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h200 || stall !== 1'b1) begin failures++; $display("FAIL lhu_wait_gnt%0d got=%b/%h/%b exp=1/00000200/1", i, dmem_req, dmem_addr, stall); end
      step();
    end
    dmem_gnt = 1;
    #1;
    checks++; if (dmem_req !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL lhu_gnt got=%b/%b exp=1/1", dmem_req, stall); end
    step();
    dmem_gnt = 0;
    #1;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL lhu_wait_rv got=%b/%b exp=0/1", dmem_req, stall); end
    step();
    dmem_rvalid = 1; dmem_rdata = 32'h80011234;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lhu_rv_stall got=%b exp=0", stall); end
    step();
    checks++; if (wbData !== 32'h00008001 || regWrOut !== 1'b1) begin failures++; $display("FAIL lhu_wb got=%h/%b exp=00008001/1", wbData, regWrOut); end
    clear_inputs();
  endtask

  task automatic test_misaligned();
    memRd = 1; memSize = 3'b010; ALUres = 32'h101; wbSel = 2'b00; rdIn = 5'd7; regWrIn = 1;
    dmem_gnt = 1;
    #1;
    checks++; if (dmem_req !== 1'b0 || misaligned !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL lw_misal got=%b/%b/%b exp=0/1/0", dmem_req, misaligned, stall); end
    step();
    checks++; if (regWrOut !== 1'b0 || rdOut !== 5'd7 || wbData !== 32'h101) begin failures++; $display("FAIL lw_misal_wb got=%b/%h/%h exp=0/07/00000101", regWrOut, rdOut, wbData); end
    clear_inputs();
    #1;
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL misal_pulse got=%b exp=0", misaligned); end
  endtask

  task automatic test_done_hold();
    memRd = 1; memSize = 3'b010; ALUres = 32'h300; wbSel = 2'b01; rdIn = 5'd9; regWrIn = 1;
    dmem_gnt = 1;
    step();
    dmem_gnt = 0; regEn = 0; dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL done_complete_stall got=%b exp=0", stall); end
    step();
    dmem_rvalid = 0; dmem_rdata = 32'h0;
    step();
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0 || wbData !== 32'h101 || regWrOut !== 1'b0) begin failures++; $display("FAIL done_hold got=%b/%b/%h/%b exp=0/0/00000101/0", stall, dmem_req, wbData, regWrOut); end
    regEn = 1;
    step();
    checks++; if (wbData !== 32'hCAFEF00D || regWrOut !== 1'b1 || rdOut !== 5'd9) begin failures++; $display("FAIL done_release got=%h/%b/%h exp=cafef00d/1/09", wbData, regWrOut, rdOut); end
    // back in IDLE, the still-present load request issues immediately
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL done_to_idle got=%b exp=1", dmem_req); end
    clear_inputs();
    rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset_mid();
    memRd = 1; memSize = 3'b010; ALUres = 32'h400; wbSel = 2'b01; rdIn = 5'd4; regWrIn = 1;
    dmem_gnt = 1;
    step();
    dmem_gnt = 0; rst = 1;
    #1;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rst_mid_comb got=%b/%b exp=0/0", dmem_req, stall); end
    step();
    rst = 0; ALUres = 32'h500; dmem_rvalid = 1; dmem_rdata = 32'h99999999;
    #1;
    checks++; if (dmem_req !== 1'b1 || stall !== 1'b1 || wbData !== 32'h0 || regWrOut !== 1'b0 || rdOut !== 5'd0) begin failures++; $display("FAIL rst_mid_idle got=%b/%b/%h/%b/%h exp=1/1/00000000/0/00", dmem_req, stall, wbData, regWrOut, rdOut); end
    step();
    dmem_rvalid = 0; dmem_gnt = 1;
    step();
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h11223344;
    step();
    checks++; if (wbData !== 32'h11223344 || regWrOut !== 1'b1) begin failures++; $display("FAIL rst_mid_recover got=%h/%b exp=11223344/1", wbData, regWrOut); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_store();
    test_lb();
    test_lhu_delayed_gnt();
    test_misaligned();
    test_done_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline MEM stage. It sits directly downstream of the execute stage and consumes its EX/MEM register outputs: ALU result, store operand B, NPC+4 and immediate. It drives a req/gnt/rvalid data-memory port, aligns store data, and extracts and extends load data. It selects the write-back value and holds the MEM/WB pipeline registers, asserting stall while a memory access is outstanding.

Parameters:
N, 32, datapath/address width (only 32 supported for byte-lane logic)
REGA, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
regEn  in  1  pipeline-register enable from CU
ALUres  in  N  effective address or ALU result
Bout  in  N  store data
NPC4_IN  in  N  PC+4 for JAL/JALR link
ImmIN  in  N  immediate (LUI path)
memRd  in  1  instruction is a load
memWr  in  1  instruction is a store
memSize  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
wbSel  in  2  00 ALU, 01 load data, 10 NPC4, 11 Imm
rdIn  in  REGA  destination register
regWrIn  in  1  register-file write enable
dmem_req  out  1  access request
dmem_we  out  1  1 = store
dmem_addr  out  N  word-aligned address {ALUres[N-1:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  N  lane-replicated store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  load data valid this cycle
dmem_rdata  in  N  load data word
stall  out  1  freeze upstream stages (combinational)
misaligned  out  1  one-cycle pulse on an alignment fault
wbData  out  N  registered MEM/WB write-back value
rdOut  out  REGA  registered destination
regWrOut  out  1  registered write enable

Behaviour:
- Reset: synchronous; state = IDLE; wbData, rdOut, regWrOut, misaligned = 0. Combinational outputs evaluate to dmem_req = 0 and stall = 0 while rst is high.
- Access type: acc = memRd | memWr. If both memRd and memWr are set, the store wins.
- Alignment: a fault occurs when H/HU is accessed with addr[0] = 1, or W with addr[1:0] != 0. On a fault: no dmem_req, misaligned = 1 for that cycle, and the stage completes immediately with regWrOut = 0.
- FSM states:
  - IDLE: if acc and regEn and aligned, drive dmem_req = 1 combinationally.
    - Store with gnt: complete this cycle.
    - Store without gnt: go to WAIT_GNT.
    - Load with gnt: go to WAIT_RV.
    - Load without gnt: go to WAIT_GNT.
  - WAIT_GNT: hold req and all dmem_* outputs stable until gnt, then take the same store-complete or load-to-WAIT_RV exits.
  - WAIT_RV: req = 0. When rvalid arrives, the load completes. rvalid is never expected in the same cycle as gnt; if it is, it is ignored.
  - DONE: entered when the access completes while regEn = 0. Holds the captured result with stall = 0. On regEn = 1, writes the MEM/WB registers and returns to IDLE.
- stall = acc & aligned & ~(completing this cycle) in IDLE, WAIT_GNT and WAIT_RV. stall = 0 in DONE.
- MEM/WB registers update on a rising edge when regEn = 1 and stall = 0. On a stall edge they load a bubble (regWrOut = 0, others held).
- Store lanes, by memSize:
  - B: be = 1 << addr[1:0], wdata = {4{Bout[7:0]}}.
  - H: be = addr[1] ? 1100 : 0011, wdata = {2{Bout[15:0]}}.
  - W: be = 1111, wdata = Bout.
  - Loads drive be = 1111 and we = 0.
- Load extraction: sh = dmem_rdata >> (8*addr[1:0]). B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- wbData mux follows wbSel. Load data goes through the DONE holding register when applicable.
- Minimum latencies:
  - Store, or a non-memory instruction: 0 stall cycles.
  - Load with gnt in cycle 0 and rvalid in cycle 1: 1 stall cycle.
- Reset mid-access: FSM returns to IDLE. A late rvalid or gnt arriving in IDLE without an active request is ignored.

Decomposition:
- Package riscv_mem_pkg:
  - mem_state_t enum {IDLE, WAIT_GNT, WAIT_RV, DONE}.
  - memSize constants MEM_B/H/W/BU/HU.
  - wbSel constants WB_ALU/WB_MEM/WB_NPC4/WB_IMM.
- Sub-module load_align: combinational rdata + addr[1:0] + memSize -> extended N-bit value.
- MEM/WB registers reuse register_generic instances.

Test Plan:
- SW, ALUres = 0x100, Bout = 0xDEADBEEF, gnt in cycle 0 -> req/we = 1, be = 1111, addr = 0x100, stall = 0, regWrOut = 0 after the edge.
- LB, ALUres = 0x203, rdata = 0x80FF_0000, gnt in cycle 0, rvalid in cycle 1 -> stall = 1 for one cycle, wbData = 0xFFFFFF80.
- LHU, ALUres = 0x202, rdata = 0x8001_1234, gnt delayed 3 cycles -> req held 3 cycles with stable address, stall = 1 until rvalid, wbData = 0x00008001.
- LW, ALUres = 0x101 -> no req, misaligned = 1 for one cycle, regWrOut = 0, stall = 0.
- Load completes while regEn = 0 -> FSM in DONE, stall = 0, wbData unchanged; regEn = 1 next -> wbData = load value, FSM in IDLE.
- rst = 1 during WAIT_RV, then rvalid arrives in cycle +1 -> all outputs 0, state IDLE, rvalid ignored.
